// File: rtl/mc_datapath_if.sv
// Control and memory bus between mc_datapath, its control unit and the
// instruction/data memories. The datapath sits on the slave modport.
interface mc_datapath_if;
    logic        pc_enable;
    logic        npc_enable;
    logic        ir_enable;
    logic        pc_select_enable;
    logic        reg_write_enable;
    logic        writeback_select_enable;
    logic        mux1_select_enable;
    logic        mux2_select_enable;
    logic        mem_write_enable;
    logic        mem_data_select_enable;
    logic [10:0] alu_op;

    logic [5:0]  opcode;
    logic [10:0] ALUfunc;
    logic        equal;
    logic [31:0] rt;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;

    modport master (
        output pc_enable, npc_enable, ir_enable, pc_select_enable,
               reg_write_enable, writeback_select_enable,
               mux1_select_enable, mux2_select_enable,
               mem_write_enable, mem_data_select_enable, alu_op,
               imem_rdata, dmem_rdata,
        input  opcode, ALUfunc, equal, rt,
               imem_addr, dmem_addr, dmem_wdata, dmem_we
    );

    modport slave (
        input  pc_enable, npc_enable, ir_enable, pc_select_enable,
               reg_write_enable, writeback_select_enable,
               mux1_select_enable, mux2_select_enable,
               mem_write_enable, mem_data_select_enable, alu_op,
               imem_rdata, dmem_rdata,
        output opcode, ALUfunc, equal, rt,
               imem_addr, dmem_addr, dmem_wdata, dmem_we
    );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: PC/NPC/IR, 32x32 register file,
// operand latches A/B, ALUOut and LMD, steered by control-unit strobes.
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    mc_datapath_if.slave bus
);

    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] lmd;
    logic [31:0] rf [32];

    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  dst_idx;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_sext;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [31:0] wb_data;
    logic        unused_alu_op_hi;

    assign rs_idx   = ir[25:21];
    assign rt_idx   = ir[20:16];
    assign dst_idx  = bus.mem_data_select_enable ? ir[15:11] : ir[20:16];
    assign rs_val   = (rs_idx == 5'd0) ? '0 : rf[rs_idx];
    assign rt_val   = (rt_idx == 5'd0) ? '0 : rf[rt_idx];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign src_a    = bus.mux1_select_enable ? a_reg : pc;
    assign src_b    = bus.mux2_select_enable ? imm_sext : b_reg;
    assign wb_data  = bus.writeback_select_enable ? lmd : alu_out;

    // Only the low six bits of alu_op select an operation.
    assign unused_alu_op_hi = ^bus.alu_op[10:6];

    // ALU operation decode; unknown codes yield zero.
    always_comb begin
        alu_result = '0;
        case (bus.alu_op[5:0])
            6'b100000: alu_result = src_a + src_b;
            6'b100010: alu_result = src_a - src_b;
            6'b100100: alu_result = src_a & src_b;
            6'b100101: alu_result = src_a | src_b;
            6'b100110: alu_result = src_a ^ src_b;
            6'b101010: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            6'b001010: alu_result = src_a;
            6'b101000: alu_result = src_a + {src_b[29:0], 2'b00};
            6'b110000: alu_result = {pc[31:28], ir[25:0], 2'b00};
            6'b111000: alu_result = src_a + src_b;
            default:   alu_result = '0;
        endcase
    end

    // All architectural and pipeline-latch state; reset overrides every write.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            npc     <= '0;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            lmd     <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (bus.npc_enable) begin
                npc <= pc + 32'd4;
            end
            if (bus.ir_enable) begin
                ir <= bus.imem_rdata;
            end
            if (bus.pc_enable) begin
                pc <= bus.pc_select_enable ? alu_out : npc;
            end
            a_reg   <= rs_val;
            b_reg   <= rt_val;
            alu_out <= alu_result;
            lmd     <= bus.dmem_rdata;
            if (bus.reg_write_enable && (dst_idx != 5'd0)) begin
                rf[dst_idx] <= wb_data;
            end
        end
    end

    assign bus.opcode     = ir[31:26];
    assign bus.ALUfunc    = ir[10:0];
    assign bus.equal      = (a_reg == b_reg);
    assign bus.rt         = b_reg;
    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = alu_out;
    assign bus.dmem_wdata = b_reg;
    assign bus.dmem_we    = bus.mem_write_enable & ~reset;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: acts as control unit and memories, and checks the
// datapath against an instruction-level architectural model.
module tb_mc_datapath;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_datapath_if bus();

    mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment memories
    logic [31:0] imem     [256];
    logic [31:0] env_dmem [256];
    assign bus.imem_rdata = imem[bus.imem_addr[9:2]];
    assign bus.dmem_rdata = env_dmem[bus.dmem_addr[9:2]];

    int unsigned we_total = 0;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    always @(posedge clk) begin
        if (bus.dmem_we === 1'b1) begin
            env_dmem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
            last_waddr <= bus.dmem_addr;
            last_wdata <= bus.dmem_wdata;
            we_total   <= we_total + 1;
        end
    end

    // Architectural model
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_mem [logic [31:0]];
    logic        m_take;
    logic [31:0] cur_word;

    logic [31:0] exp_rt, exp_pc, exp_waddr, exp_wdata;
    logic        exp_equal;
    int unsigned exp_we_cnt;

    logic [31:0] obs_rt, obs_pc, obs_pc_pre, obs_waddr, obs_wdata;
    logic        obs_equal;
    logic [5:0]  obs_opcode;
    logic [10:0] obs_func;
    int unsigned obs_we_cnt;

    // Control strobes for the instruction in IR
    logic [10:0] c_alu_op;
    logic c_mux1, c_mux2, c_wb, c_dsel, c_wr, c_sw, c_take;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {OP_R, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] idx);
        return {OP_J, idx};
    endfunction

    function automatic logic [31:0] probe(input logic [4:0] r);
        return enc_r(6'h20, 5'd0, r, 5'd0, 5'd0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr);
        return m_mem.exists(addr) ? m_mem[addr] : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc     = 32'h0000_0000;
        cur_word = '0;
    endtask

    // Executes one instruction at the ISA level. The word fetched alongside a
    // branch is always the sequential one; the branch only redirects PC.
    task automatic model_exec(input logic [31:0] w);
        logic [31:0] va, vb, simm, res, addr, target;
        logic taken;
        va     = m_regs[w[25:21]];
        vb     = m_regs[w[20:16]];
        simm   = {{16{w[15]}}, w[15:0]};
        taken  = 1'b0;
        target = '0;
        exp_rt     = vb;
        exp_equal  = (va == vb);
        exp_we_cnt = 0;
        case (w[31:26])
            OP_R: begin
                case (w[5:0])
                    6'h20:   res = va + vb;
                    6'h22:   res = va - vb;
                    6'h24:   res = va & vb;
                    6'h25:   res = va | vb;
                    6'h26:   res = va ^ vb;
                    6'h2A:   res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                    default: res = 32'd0;
                endcase
                if (w[15:11] != 5'd0) m_regs[w[15:11]] = res;
            end
            OP_ADDI: if (w[20:16] != 5'd0) m_regs[w[20:16]] = va + simm;
            OP_LW: begin
                addr = va + simm;
                if (w[20:16] != 5'd0) m_regs[w[20:16]] = m_load(addr);
            end
            OP_SW: begin
                addr = va + simm;
                m_mem[addr] = vb;
                exp_we_cnt = 1;
                exp_waddr  = addr;
                exp_wdata  = vb;
            end
            OP_BNE: begin
                taken  = (va != vb);
                target = m_pc + (simm << 2);
            end
            OP_J: begin
                taken  = 1'b1;
                target = {m_pc[31:28], w[25:0], 2'b00};
            end
            default: ;
        endcase
        m_take = taken;
        m_pc   = taken ? target : m_pc + 32'd4;
        exp_pc = m_pc;
    endtask

    // Control-unit emulation: strobes held for the whole instruction.
    task automatic decode_ctl(input logic [31:0] w, input logic take);
        c_alu_op = '0; c_mux1 = 1'b1; c_mux2 = 1'b0; c_wb = 1'b0;
        c_dsel = 1'b0; c_wr = 1'b0; c_sw = 1'b0; c_take = take;
        case (w[31:26])
            OP_R:    begin c_alu_op = w[10:0]; c_dsel = 1'b1; c_wr = 1'b1; end
            OP_ADDI: begin c_alu_op = 11'h020; c_mux2 = 1'b1; c_wr = 1'b1; end
            OP_LW:   begin c_alu_op = 11'h038; c_mux2 = 1'b1; c_wb = 1'b1; c_wr = 1'b1; end
            OP_SW:   begin c_alu_op = 11'h038; c_mux2 = 1'b1; c_sw = 1'b1; end
            OP_BNE:  begin c_alu_op = 11'h028; c_mux1 = 1'b0; c_mux2 = 1'b1; end
            OP_J:    begin c_alu_op = 11'h030; end
            default: ;
        endcase
    endtask

    task automatic drive_state(input int s, input logic rst);
        @(negedge clk);
        reset                       = rst;
        bus.alu_op                  = c_alu_op;
        bus.mux1_select_enable      = c_mux1;
        bus.mux2_select_enable      = c_mux2;
        bus.writeback_select_enable = c_wb;
        bus.mem_data_select_enable  = c_dsel;
        bus.npc_enable              = 1'b1;
        bus.ir_enable               = (s == 4);
        bus.pc_enable               = (s == 4);
        bus.pc_select_enable        = (s == 4) && c_take;
        bus.reg_write_enable        = (s == 3) && c_wr;
        bus.mem_write_enable        = (s == 2) && c_sw;
        #1;
    endtask

    // Runs the five states of the instruction in IR and fetches next_word.
    task automatic run_instr(input logic [31:0] next_word);
        int unsigned we_before;
        imem[m_pc[9:2]] = next_word;
        model_exec(cur_word);
        decode_ctl(cur_word, m_take);
        we_before = we_total;
        for (int s = 0; s < 5; s++) begin
            drive_state(s, 1'b0);
            if (s == 1) begin
                obs_rt    = bus.rt;
                obs_equal = bus.equal;
            end
            if (s == 4) obs_pc_pre = bus.imem_addr;
            @(posedge clk);
        end
        #1;
        obs_pc     = bus.imem_addr;
        obs_opcode = bus.opcode;
        obs_func   = bus.ALUfunc;
        obs_we_cnt = we_total - we_before;
        obs_waddr  = last_waddr;
        obs_wdata  = last_wdata;
        cur_word   = next_word;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.pc_enable               = 1'($urandom_range(0, 1));
            bus.npc_enable              = 1'($urandom_range(0, 1));
            bus.ir_enable               = 1'($urandom_range(0, 1));
            bus.pc_select_enable        = 1'($urandom_range(0, 1));
            bus.reg_write_enable        = 1'($urandom_range(0, 1));
            bus.writeback_select_enable = 1'($urandom_range(0, 1));
            bus.mux1_select_enable      = 1'($urandom_range(0, 1));
            bus.mux2_select_enable      = 1'($urandom_range(0, 1));
            bus.mem_data_select_enable  = 1'($urandom_range(0, 1));
            bus.mem_write_enable        = 1'b1;
            bus.alu_op                  = 11'($urandom);
            #1;
            n_checks++;
            if (bus.dmem_we !== 1'b0) begin
                n_errors++; $display("FAIL reset_dmem_we got %b want 0", bus.dmem_we);
            end
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (bus.imem_addr !== 32'h0 || bus.opcode !== 6'h0 || bus.ALUfunc !== 11'h0 ||
            bus.equal !== 1'b1 || bus.rt !== 32'h0 || bus.dmem_addr !== 32'h0 ||
            bus.dmem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got pc=%h op=%h fn=%h eq=%b rt=%h da=%h dw=%h want pc=0 op=0 fn=0 eq=1 rt=0 da=0 dw=0",
                     bus.imem_addr, bus.opcode, bus.ALUfunc, bus.equal, bus.rt,
                     bus.dmem_addr, bus.dmem_wdata);
        end
        model_reset();
        for (int r = 0; r <= 32; r++) begin
            run_instr((r < 32) ? probe(5'(r)) : 32'h0);
            if (r == 0) begin
                n_checks++;
                if (obs_pc !== 32'h4 || obs_opcode !== 6'h0 || obs_func !== 11'h020) begin
                    n_errors++;
                    $display("FAIL first_fetch got pc=%h op=%h fn=%h want pc=4 op=0 fn=020",
                             obs_pc, obs_opcode, obs_func);
                end
            end else begin
                n_checks++;
                if (obs_rt !== 32'h0) begin
                    n_errors++; $display("FAIL reset_reg r%0d got %h want 0", r - 1, obs_rt);
                end
            end
        end
    endtask

    task automatic test_add();
        logic [31:0] words [7];
        words = '{enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5), enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7),
                  enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), enc_r(6'h20, 5'd1, 5'd2, 5'd0, 5'd0),
                  probe(5'd3), probe(5'd0), 32'h0};
        for (int i = 0; i < 7; i++) begin
            run_instr(words[i]);
            n_checks++;
            if (obs_rt !== exp_rt || obs_equal !== exp_equal || obs_pc !== exp_pc) begin
                n_errors++;
                $display("FAIL add_step%0d got rt=%h eq=%b pc=%h want rt=%h eq=%b pc=%h",
                         i, obs_rt, obs_equal, obs_pc, exp_rt, exp_equal, exp_pc);
            end
            if (i == 5) begin
                n_checks++;
                if (obs_rt !== 32'd12) begin
                    n_errors++; $display("FAIL add_r3 got %h want 0000000c", obs_rt);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (obs_rt !== 32'd0) begin
                    n_errors++; $display("FAIL add_r0 got %h want 0", obs_rt);
                end
            end
        end
    endtask

    task automatic test_sw_lw();
        logic [31:0] words [8];
        words = '{enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0100), enc_i(OP_ADDI, 5'd0, 5'd2, 16'h6F56),
                  enc_r(6'h20, 5'd2, 5'd2, 5'd2, 5'd0), enc_i(OP_ADDI, 5'd2, 5'd2, 16'd1),
                  enc_i(OP_SW, 5'd1, 5'd2, 16'd8), enc_i(OP_LW, 5'd1, 5'd4, 16'd8),
                  probe(5'd4), 32'h0};
        for (int i = 0; i < 8; i++) begin
            run_instr(words[i]);
            n_checks++;
            if (obs_rt !== exp_rt || obs_pc !== exp_pc || obs_we_cnt != exp_we_cnt) begin
                n_errors++;
                $display("FAIL swlw_step%0d got rt=%h pc=%h we=%0d want rt=%h pc=%h we=%0d",
                         i, obs_rt, obs_pc, obs_we_cnt, exp_rt, exp_pc, exp_we_cnt);
            end
            if (i == 5) begin
                n_checks++;
                if (obs_we_cnt != 1 || obs_waddr !== 32'h108 || obs_wdata !== 32'hDEAD) begin
                    n_errors++;
                    $display("FAIL sw_write got cycles=%0d addr=%h data=%h want cycles=1 addr=108 data=dead",
                             obs_we_cnt, obs_waddr, obs_wdata);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (obs_rt !== 32'hDEAD) begin
                    n_errors++; $display("FAIL lw_r4 got %h want 0000dead", obs_rt);
                end
            end
        end
    endtask

    task automatic test_bne();
        logic [31:0] words [9];
        words = '{enc_j(26'h8), 32'h0, enc_i(OP_BNE, 5'd1, 5'd2, 16'd3), 32'h0,
                  enc_r(6'h20, 5'd1, 5'd0, 5'd2, 5'd0),
                  enc_j(26'h8), 32'h0, enc_i(OP_BNE, 5'd1, 5'd2, 16'd3), 32'h0};
        for (int i = 0; i < 9; i++) begin
            run_instr(words[i]);
            n_checks++;
            if (obs_pc !== exp_pc || obs_equal !== exp_equal) begin
                n_errors++;
                $display("FAIL bne_step%0d got pc=%h eq=%b want pc=%h eq=%b",
                         i, obs_pc, obs_equal, exp_pc, exp_equal);
            end
            if (i == 3) begin
                n_checks++;
                if (obs_equal !== 1'b0 || obs_pc_pre !== 32'h24 || obs_pc !== 32'h30) begin
                    n_errors++;
                    $display("FAIL bne_taken got eq=%b pc_before=%h pc_after=%h want eq=0 pc_before=24 pc_after=30",
                             obs_equal, obs_pc_pre, obs_pc);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (obs_equal !== 1'b1 || obs_pc_pre !== 32'h24) begin
                    n_errors++;
                    $display("FAIL bne_not_taken got eq=%b pc=%h want eq=1 pc=24",
                             obs_equal, obs_pc_pre);
                end
            end
        end
    endtask

    task automatic test_jmp();
        logic [31:0] words [4];
        words = '{enc_j(26'h10), 32'h0, enc_j(26'h10), 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_instr(words[i]);
            n_checks++;
            if (obs_pc !== exp_pc) begin
                n_errors++; $display("FAIL jmp_step%0d got pc=%h want %h", i, obs_pc, exp_pc);
            end
        end
        n_checks++;
        if (obs_pc_pre !== 32'h44 || obs_pc !== 32'h40) begin
            n_errors++;
            $display("FAIL jmp_target got pc_before=%h pc_after=%h want pc_before=44 pc_after=40",
                     obs_pc_pre, obs_pc);
        end
    endtask

    task automatic test_random();
        logic [5:0]  functs [6];
        logic [31:0] w;
        int unsigned k;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
        for (int i = 0; i <= 60; i++) begin
            k = $urandom_range(0, 9);
            if (i == 60)
                w = 32'h0;
            else if (k < 3)
                w = enc_i(OP_ADDI, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            else if (k < 8)
                w = enc_r(functs[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
            else if (k == 8)
                w = enc_i(OP_SW, 5'd0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63) * 4));
            else
                w = enc_i(OP_LW, 5'd0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63) * 4));
            run_instr(w);
            n_checks++;
            if (obs_rt !== exp_rt || obs_equal !== exp_equal || obs_pc !== exp_pc ||
                obs_we_cnt != exp_we_cnt || obs_opcode !== w[31:26] || obs_func !== w[10:0]) begin
                n_errors++;
                $display("FAIL rand_step%0d got rt=%h eq=%b pc=%h we=%0d op=%h fn=%h want rt=%h eq=%b pc=%h we=%0d op=%h fn=%h",
                         i, obs_rt, obs_equal, obs_pc, obs_we_cnt, obs_opcode, obs_func,
                         exp_rt, exp_equal, exp_pc, exp_we_cnt, w[31:26], w[10:0]);
            end
            if (exp_we_cnt == 1) begin
                n_checks++;
                if (obs_waddr !== exp_waddr || obs_wdata !== exp_wdata) begin
                    n_errors++;
                    $display("FAIL rand_store%0d got addr=%h data=%h want addr=%h data=%h",
                             i, obs_waddr, obs_wdata, exp_waddr, exp_wdata);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int unsigned we_before;
        logic [31:0] sw_word;
        sw_word = enc_i(OP_SW, 5'd1, 5'd2, 16'd8);
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0040));
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd2, 16'h0055));
        run_instr(sw_word);
        run_instr(sw_word);
        decode_ctl(sw_word, 1'b0);
        we_before = we_total;
        drive_state(0, 1'b0);
        @(posedge clk);
        drive_state(1, 1'b0);
        @(posedge clk);
        drive_state(2, 1'b1);
        n_checks++;
        if (bus.dmem_we !== 1'b0) begin
            n_errors++; $display("FAIL midreset_we got %b want 0", bus.dmem_we);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (we_total != we_before) begin
            n_errors++; $display("FAIL midreset_writes got %0d want 0", we_total - we_before);
        end
        n_checks++;
        if (bus.imem_addr !== 32'h0 || bus.opcode !== 6'h0 || bus.ALUfunc !== 11'h0 ||
            bus.equal !== 1'b1 || bus.rt !== 32'h0 || bus.dmem_addr !== 32'h0 ||
            bus.dmem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs got pc=%h op=%h fn=%h eq=%b rt=%h da=%h dw=%h want pc=0 op=0 fn=0 eq=1 rt=0 da=0 dw=0",
                     bus.imem_addr, bus.opcode, bus.ALUfunc, bus.equal, bus.rt,
                     bus.dmem_addr, bus.dmem_wdata);
        end
        model_reset();
        for (int r = 0; r <= 32; r++) begin
            run_instr((r < 32) ? probe(5'(r)) : 32'h0);
            n_checks++;
            if ((r == 0 && obs_pc !== 32'h4) || (r > 0 && obs_rt !== 32'h0)) begin
                n_errors++;
                $display("FAIL midreset_state step%0d got pc=%h rt=%h want pc=4 (step0) rt=0",
                         r, obs_pc, obs_rt);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i]     = '0;
            env_dmem[i] = '0;
        end
        reset = 1'b1;
        test_reset();
        test_add();
        test_sw_lw();
        test_bne();
        test_jmp();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
